shift_rows_pipe: RTL and testbench
==================================

Name: shift_rows_pipe

Overview:
Forward AES ShiftRows stage for the encryption datapath. It is the encrypt-side counterpart of the decrypt-side inverse permutation. It accepts 128-bit state blocks over a valid/ready handshake, applies the forward ShiftRows permutation, and presents results through a 2-entry elastic output buffer. It sits between SubBytes and MixColumns in the encryption round pipeline and keeps a count of blocks delivered.

Parameters:
CNT_W, 16, width of the delivered-block counter.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous reset, active-high.
flush  input  1  synchronous clear of buffered blocks; counter is kept.
in_valid  input  1  upstream block valid.
in_ready  output  1  stage can accept a block this cycle.
in_block  input  128  state block, row-major layout.
in_last  input  1  final-round tag, carried alongside the block.
out_valid  output  1  out_block holds a valid shifted block.
out_ready  input  1  downstream accepts this cycle.
out_block  output  128  ShiftRows(in_block).
out_last  output  1  tag travelling with out_block.
blk_count  output  CNT_W  number of output handshakes since reset.

Behaviour:
- Clocking and reset: one clock, `clk`. Reset `rst` is synchronous and active-high.
- Block layout (row-major):
  - Row r occupies bits [127-32r : 96-32r].
  - Within a row, the byte at the highest bits is column 0.
- Forward ShiftRows: row r rotates left by r bytes.
  - row0 = in[127:96]
  - row1 = {in[87:64], in[95:88]}
  - row2 = {in[47:32], in[63:48]}
  - row3 = {in[7:0], in[31:8]}
- Permutation is applied on the input side, before storage. Stored entries are already shifted.
- Buffer: head register H (drives out_*) and skid register S. State machine over {EMPTY, ONE, TWO}.
- Handshake definitions:
  - Accept = in_valid & in_ready.
  - Deliver = out_valid & out_ready.
- Transitions:
  - EMPTY: accept -> load H, go ONE.
  - ONE:
    - accept & !deliver -> load S, go TWO.
    - deliver & !accept -> EMPTY.
    - both -> load H with new block, stay ONE.
  - TWO:
    - deliver -> H <= S, go ONE.
    - in_ready is 0, so no accept in TWO.
- Output decodes:
  - in_ready = (state != TWO). Registered decode; no combinational path from out_ready.
  - out_valid = (state != EMPTY).
- Latency: 1 cycle from accept to out_valid when EMPTY. Sustained throughput is 1 block/cycle when out_ready is held high.
- Ordering: strict FIFO. out_last always travels with its own block.
- Stall: out_block and out_last are stable while out_valid & !out_ready.
- blk_count: +1 on each deliver. Wraps from 2^CNT_W-1 to 0. Not affected by flush.
- flush: next state is EMPTY and in-flight blocks are discarded.
  - An accept in the same cycle as flush is dropped.
  - A deliver in the same cycle as flush still counts.
- Reset (rst=1):
  - State EMPTY; out_valid=0; in_ready=1 from the following cycle.
  - out_block=0, out_last=0, blk_count=0.
  - Reset takes priority over flush and handshakes, including mid-stream.
- H and S data registers are reset to 0. out_block must read 0 whenever out_valid=0 after reset or flush.

Decomposition:
- Package aes_pkg:
  - typedef aes_block_t as logic [127:0]
  - typedef buf_state_t enum {EMPTY, ONE, TWO}
  - constants ROW_W=32 and BYTE_W=8
- Sub-module shift_rows_fwd: pure combinational forward permutation, 128-bit in/out, instantiated once at the input.

Test Plan:
1. Reset, then single block 0x00010203_04050607_08090a0b_0c0d0e0f with in_last=1 and out_ready=1 -> next cycle out_valid=1, out_block=0x00010203_05060704_0a0b0809_0f0c0d0e, out_last=1, blk_count becomes 1.
2. Back-to-back stream of 8 blocks with out_ready=1 and in_valid held high -> in_ready stays 1, 8 outputs on consecutive cycles in order, blk_count=8.
3. out_ready=0 while 3 blocks are offered -> first two accepted, in_ready=0 after the second, out_block held stable. Raise out_ready -> blocks emerge in order, third accepted once in_ready=1.
4. Random out_ready/in_valid toggling over 1000 blocks against a scoreboard using the row-rotation model -> no loss, duplication or reorder; out_last matched per block.
5. Buffer in TWO, assert flush for 1 cycle with in_valid=1 -> out_valid=0 next cycle, offered block dropped, blk_count unchanged.
6. Preload blk_count to 0xFFFF via 65535 delivers (or a force), then one more deliver -> blk_count=0x0000. Assert rst mid-stream -> all outputs return to reset values the following cycle.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES encryption round datapath.
package aes_pkg;

  localparam int ROW_W  = 32;
  localparam int BYTE_W = 8;

  typedef logic [127:0] aes_block_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_t;

endpackage

// File: rtl/shift_rows_fwd.sv
// Forward AES ShiftRows on a row-major block: row r rotates left by r bytes.
module shift_rows_fwd
  import aes_pkg::*;
(
  input  aes_block_t in_block,
  output aes_block_t out_block
);

  logic [ROW_W-1:0] row0, row1, row2, row3;

  assign row0 = in_block[127:96];
  assign row1 = in_block[95:64];
  assign row2 = in_block[63:32];
  assign row3 = in_block[31:0];

  assign out_block = {
    row0,
    {row1[ROW_W-BYTE_W-1:0],   row1[ROW_W-1 -: BYTE_W]},
    {row2[ROW_W-2*BYTE_W-1:0], row2[ROW_W-1 -: 2*BYTE_W]},
    {row3[BYTE_W-1:0],         row3[ROW_W-1 -: 3*BYTE_W]}
  };

endmodule

// File: rtl/shift_rows_pipe.sv
// ShiftRows stage with a 2-entry elastic output buffer (head H + skid S) and delivered-block counter.
module shift_rows_pipe
  import aes_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_block,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_block,
  output logic             out_last,
  output logic [CNT_W-1:0] blk_count
);

  aes_block_t       shifted;
  buf_state_t       state_q, state_d;
  aes_block_t       h_q, h_d, s_q, s_d;
  logic             h_last_q, h_last_d, s_last_q, s_last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept, deliver;

  shift_rows_fwd u_fwd (
    .in_block  (in_block),
    .out_block (shifted)
  );

  // Both decodes come straight from the state register, so in_ready never depends on out_ready.
  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid & in_ready;
  assign deliver   = out_valid & out_ready;

  always_comb begin
    state_d  = state_q;
    h_d      = h_q;
    h_last_d = h_last_q;
    s_d      = s_q;
    s_last_d = s_last_q;
    cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, deliver};

    if (flush) begin
      state_d  = EMPTY;
      h_d      = '0;
      h_last_d = 1'b0;
      s_d      = '0;
      s_last_d = 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            h_d      = shifted;
            h_last_d = in_last;
            state_d  = ONE;
          end
        end
        ONE: begin
          if (accept && deliver) begin
            h_d      = shifted;
            h_last_d = in_last;
          end else if (accept) begin
            s_d      = shifted;
            s_last_d = in_last;
            state_d  = TWO;
          end else if (deliver) begin
            // Keep the head at zero whenever nothing is presented.
            h_d      = '0;
            h_last_d = 1'b0;
            state_d  = EMPTY;
          end
        end
        TWO: begin
          if (deliver) begin
            h_d      = s_q;
            h_last_d = s_last_q;
            s_d      = '0;
            s_last_d = 1'b0;
            state_d  = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EMPTY;
      h_q      <= '0;
      h_last_q <= 1'b0;
      s_q      <= '0;
      s_last_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      h_q      <= h_d;
      h_last_q <= h_last_d;
      s_q      <= s_d;
      s_last_q <= s_last_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_block = h_q;
  assign out_last  = h_last_q;
  assign blk_count = cnt_q;

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Bench for shift_rows_pipe: constant vectors, directed corner sequences and a queue-based random scoreboard.
module tb_shift_rows_pipe;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_block = '0;
  logic         in_last = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_block;
  logic         out_last;
  logic [15:0]  blk_count;

  shift_rows_pipe #(.CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_block  (in_block),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_block (out_block),
    .out_last  (out_last),
    .blk_count (blk_count)
  );

  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  // Reference state: ordered list of {last, shifted block} pending delivery, plus delivered count.
  logic [128:0] mq[$];
  logic [15:0]  mcnt = '0;
  logic         m_acc;
  logic         m_dlv;

  typedef struct {
    logic [127:0] blk;
    logic         last;
    logic [127:0] exp;
  } vec_t;

  vec_t tv[6];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s got=%h expected=%h t=%0t", name, act, exp, $time);
  endtask

  // Byte-matrix view: state byte (r,c) sits at bits [127-8*(4r+c) -: 8]; output (r,c) = input (r,(c+r) mod 4).
  function automatic logic [127:0] ref_shift(input logic [127:0] x);
    logic [7:0]   b[4][4];
    logic [127:0] y;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        b[r][c] = x[127-8*(4*r+c) -: 8];
    y = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        y[127-8*(4*r+c) -: 8] = b[r][(c+r)%4];
    return y;
  endfunction

  task automatic cycle(input logic r, input logic fl, input logic iv,
                       input logic [127:0] b, input logic l, input logic ordy);
    rst = r; flush = fl; in_valid = iv; in_block = b; in_last = l; out_ready = ordy;
    m_acc = iv && (mq.size() < 2) && !fl && !r;
    m_dlv = (mq.size() > 0) && ordy && !r;
    @(posedge clk);
    #1;
    if (r) begin
      mq.delete();
      mcnt = '0;
    end else begin
      if (m_dlv) mcnt = mcnt + 16'd1;
      if (fl) mq.delete();
      else begin
        if (m_dlv) void'(mq.pop_front());
        if (m_acc) mq.push_back({l, ref_shift(b)});
      end
    end
    chk("out_valid", 128'(out_valid), 128'(mq.size() != 0));
    chk("in_ready",  128'(in_ready),  128'(mq.size() < 2));
    chk("blk_count", 128'(blk_count), 128'(mcnt));
    if (mq.size() != 0) begin
      chk("out_block", out_block, mq[0][127:0]);
      chk("out_last",  128'(out_last), 128'(mq[0][128]));
    end else begin
      chk("out_block_idle", out_block, 128'd0);
      chk("out_last_idle",  128'(out_last), 128'd0);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [15:0]  base;
    logic [127:0] b2;
    int           got;
    int           cyc;

    tv[0] = '{128'h00010203_04050607_08090a0b_0c0d0e0f, 1'b1, 128'h00010203_05060704_0a0b0809_0f0c0d0e};
    tv[1] = '{128'hffffffff_ffffffff_ffffffff_ffffffff, 1'b0, 128'hffffffff_ffffffff_ffffffff_ffffffff};
    tv[2] = '{128'h00000000_11223344_00000000_00000000, 1'b1, 128'h00000000_22334411_00000000_00000000};
    tv[3] = '{128'h00000000_00000000_aabbccdd_00000000, 1'b0, 128'h00000000_00000000_ccddaabb_00000000};
    tv[4] = '{128'h00000000_00000000_00000000_01020304, 1'b1, 128'h00000000_00000000_00000000_04010203};
    tv[5] = '{128'h10111213_14151617_18191a1b_1c1d1e1f, 1'b0, 128'h10111213_15161714_1a1b1819_1f1c1d1e};

    // Reset state
    cycle(1, 0, 0, '0, 0, 0);
    cycle(1, 0, 1, 128'h1, 1, 1);
    cycle(0, 0, 0, '0, 0, 0);
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_blk_count", 128'(blk_count), 128'd0);

    // Constant vectors, one accept per cycle, one-cycle latency
    for (int i = 0; i < 6; i++) begin
      cycle(0, 0, 1, tv[i].blk, tv[i].last, 1);
      chk("vec_block", out_block, tv[i].exp);
      chk("vec_last", 128'(out_last), 128'(tv[i].last));
      chk("vec_count", 128'(blk_count), 128'(i));
    end
    cycle(0, 0, 0, '0, 0, 1);
    chk("vec_final_count", 128'(blk_count), 128'd6);

    // Back-to-back stream of 8
    base = mcnt;
    for (int i = 0; i < 8; i++) cycle(0, 0, 1, rnd128(), i[0], 1);
    cycle(0, 0, 0, '0, 0, 1);
    chk("stream_count", 128'(blk_count), 128'(base + 16'd8));

    // Stall with three offers; third waits until in_ready returns
    b2 = rnd128();
    cycle(0, 0, 1, rnd128(), 0, 0);
    cycle(0, 0, 1, rnd128(), 1, 0);
    chk("stall_full", 128'(in_ready), 128'd0);
    cycle(0, 0, 1, b2, 1, 0);
    cycle(0, 0, 1, b2, 1, 0);
    got = 0;
    for (int i = 0; i < 10 && got == 0; i++) begin
      cycle(0, 0, 1, b2, 1, 1);
      if (m_acc) got = 1;
    end
    chk("stall_third_accepted", 128'(got), 128'd1);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, '0, 0, 1);

    // Flush while full with a concurrent offer
    cycle(0, 0, 1, rnd128(), 0, 0);
    cycle(0, 0, 1, rnd128(), 1, 0);
    base = mcnt;
    cycle(0, 1, 1, rnd128(), 1, 0);
    chk("flush_valid", 128'(out_valid), 128'd0);
    chk("flush_count", 128'(blk_count), 128'(base));
    // Flush coinciding with a deliver still counts it
    cycle(0, 0, 1, rnd128(), 1, 0);
    cycle(0, 1, 1, rnd128(), 0, 1);
    chk("flush_dlv_count", 128'(blk_count), 128'(base + 16'd1));
    cycle(0, 0, 0, '0, 0, 0);

    // Random traffic: 1000 accepted blocks
    base = mcnt;
    got = 0;
    cyc = 0;
    while ((got < 1000 || mq.size() != 0) && cyc < 20000) begin
      cycle(0, 0, (got < 1000) && ($urandom_range(3) != 0), rnd128(), 1'($urandom), $urandom_range(2) != 0);
      if (m_acc) got++;
      cyc++;
    end
    chk("rand_done", 128'(cyc < 20000), 128'd1);
    chk("rand_count", 128'(blk_count), 128'(base + 16'd1000));

    // Counter wrap
    cycle(1, 0, 0, '0, 0, 0);
    cyc = 0;
    while (mcnt != 16'hffff && cyc < 70000) begin
      cycle(0, 0, 1, rnd128(), 1'($urandom), 1);
      cyc++;
    end
    chk("wrap_reached", 128'(blk_count), 128'hffff);
    cycle(0, 0, 0, '0, 0, 1);
    chk("wrap_zero", 128'(blk_count), 128'd0);

    // Mid-stream reset
    cycle(0, 0, 1, rnd128(), 1, 0);
    cycle(0, 0, 1, rnd128(), 1, 0);
    cycle(1, 0, 1, rnd128(), 1, 1);
    chk("mid_rst_valid", 128'(out_valid), 128'd0);
    chk("mid_rst_block", out_block, 128'd0);
    chk("mid_rst_last", 128'(out_last), 128'd0);
    chk("mid_rst_count", 128'(blk_count), 128'd0);
    chk("mid_rst_ready", 128'(in_ready), 128'd1);
    cycle(0, 0, 0, '0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
